alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
// - Parametrised multi-cycle successor to the 16-bit datapath ALU. Executes the same opcode set at WIDTH bits.
// - Registered result and NZCO flags; valid/ready handshakes on both sides.
// - Single-cycle ops take 1 cycle; MUL/DIV/MOD run an iterative shift-add / restoring-divide engine.
// - Sits between the register-file read stage and writeback; the control FSM stalls on in_ready=0.
// PARAMETERS
// - WIDTH  16  operand/result width (>=4, power of 2)
// - OPW     6  opcode width
// PORTS
// - clk        in   1      one clock; all state on rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - in_valid   in   1      operation request
// - in_ready   out  1      1 only in IDLE
// - store      in   1      pass-through: result=A, flags unchanged, 1-cycle
// - opcode     in   OPW    operation (alu_pkg encodings)
// - a, b       in   WIDTH  operands, sampled on accept
// - out_valid  out  1      result available
// - out_ready  in   1      consumer accepts result
// - result     out  WIDTH  registered result
// - flags      out  4      {Z,N,C,O}, registered
// - illegal    out  1      unsupported opcode; qualified by out_valid
// BEHAVIOUR
// - Reset (async): state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, illegal=0.
// - Accept = in_valid & in_ready; a, b, opcode and store are latched. Inputs are ignored otherwise.
// - FSM states: IDLE, BUSY, DONE.
//   - IDLE -accept, 1-cycle op-> DONE.
//   - IDLE -accept, MUL/DIV/MOD-> BUSY.
//   - BUSY -after WIDTH iterations-> DONE.
//   - DONE -out_ready-> IDLE.
// - Latency:
//   - 1-cycle ops: out_valid rises on the edge after accept.
//   - MUL/DIV/MOD: out_valid rises WIDTH+1 edges after accept.
// - result, flags and illegal are held stable while out_valid=1 and out_ready=0.
// - No accept in DONE, even when out_ready=1 in that cycle. Minimum issue interval is 2 cycles.
// - Flags: Z=(result==0) and N=result[WIDTH-1] unless stated otherwise.
//   - ADD: C=carry-out of a+b; O=signed overflow.
//   - SUB/CMP: C=borrow (a<b unsigned); O=signed overflow. CMP writes flags and result.
//   - LSR/LSL: shift by b; b>=WIDTH gives 0. C=last bit shifted out (0 if b==0). O=0.
//   - RSR/RSL: rotate by b mod WIDTH. C=0, O=0.
//   - MOV: result=b; flags=0.
//   - MUL: low WIDTH bits of unsigned product; C=0; O=(high half != 0).
//   - DIV/MOD: unsigned quotient/remainder; C=0, O=0.
//     - Divide by zero: DIV result=all-ones, MOD result=a, O=1.
//   - AND/TST, OR, XOR, NOT: C=0, O=0.
//   - INC/DEC: C=0; O=1 on wrap (a=max for INC, a=0 for DEC).
// - Illegal opcode: result=0, flags unchanged, illegal=1; takes 1 cycle.
// - store=1 overrides opcode: result=a, flags unchanged, illegal=0.
// - Reset mid-BUSY aborts the operation: no out_valid and no flag update.
// STRUCTURE
// - alu_pkg holds:
//   - opcode localparams (ADD 0A, SUB 0B, LSR 0C, LSL 0D, RSR 0E, RSL 0F, MOV 10, MUL 11,
//     DIV 12, MOD 13, AND 14, OR 15, XOR 16, NOT 17, CMP 18, TST 19, INC 1A, DEC 1B)
//   - FSM state typedef
//   - flag bit indices
// - Sub-module alu_iter_muldiv (WIDTH):
//   - start/done interface
//   - one radix-2 step per cycle
//   - returns product {hi,lo} or {quotient,remainder}
// TESTING
// - ADD a=7FFF, b=0001 -> result=8000, flags Z0 N1 C0 O1; out_valid 1 cycle after accept.
// - SUB a=0003, b=0005 -> result=FFFE, N1 C1 O0. CMP a=b=1234 -> Z1.
// - MUL a=0100, b=0100 -> result=0000, Z1 O1, out_valid exactly 17 cycles after accept;
//   in_ready=0 throughout.
// - DIV a=0064, b=0007 -> 000E; MOD -> 0002. DIV by 0 -> FFFF, O1.
// - Backpressure: hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
//   Then 1-cycle out_ready -> IDLE.
// - Illegal opcode 3F -> illegal=1, flags unchanged.
// - rst_n low during BUSY -> all outputs at reset values immediately; the next op runs clean.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, FSM state type and flag bit positions shared by alu_seq and its bench
package alu_pkg;
  localparam logic [5:0] OP_ADD = 6'h0A;
  localparam logic [5:0] OP_SUB = 6'h0B;
  localparam logic [5:0] OP_LSR = 6'h0C;
  localparam logic [5:0] OP_LSL = 6'h0D;
  localparam logic [5:0] OP_RSR = 6'h0E;
  localparam logic [5:0] OP_RSL = 6'h0F;
  localparam logic [5:0] OP_MOV = 6'h10;
  localparam logic [5:0] OP_MUL = 6'h11;
  localparam logic [5:0] OP_DIV = 6'h12;
  localparam logic [5:0] OP_MOD = 6'h13;
  localparam logic [5:0] OP_AND = 6'h14;
  localparam logic [5:0] OP_OR  = 6'h15;
  localparam logic [5:0] OP_XOR = 6'h16;
  localparam logic [5:0] OP_NOT = 6'h17;
  localparam logic [5:0] OP_CMP = 6'h18;
  localparam logic [5:0] OP_TST = 6'h19;
  localparam logic [5:0] OP_INC = 6'h1A;
  localparam logic [5:0] OP_DEC = 6'h1B;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: radix-2 iterative unsigned multiplier / restoring divider, one step per cycle
// Ports: clk, rst_n; start/is_div/a/b load an operation; done is high during the final step,
// when hi/lo already present the finished {product hi, lo} or {remainder, quotient}.
module alu_iter_muldiv #(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  logic busy_q, busy_d, div_q, div_d, ge;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, diff;
  logic [WIDTH:0] sum, sh;
  // mul: hi:lo = accumulator:multiplier, m = multiplicand
  // div: hi:lo = partial remainder:dividend (quotient bits shift in at lo[0]), m = divisor
  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    sh = {hi_q, lo_q[WIDTH-1]};
    ge = sh >= {1'b0, m_q};
    diff = sh[WIDTH-1:0] - m_q;
    done = busy_q && cnt_q == CW'(WIDTH - 1);
    busy_d = busy_q;
    cnt_d = cnt_q;
    div_d = div_q;
    m_d = m_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d = '0;
      div_d = is_div;
      m_d = is_div ? b : a;
      hi_d = '0;
      lo_d = is_div ? a : b;
    end else if (busy_q) begin
      busy_d = !done;
      cnt_d = cnt_q + 1'b1;
      {hi_d, lo_d} = div_q ? {ge ? diff : sh[WIDTH-1:0], lo_q[WIDTH-2:0], ge} : {sum, lo_q[WIDTH-1:1]};
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
      div_q <= 1'b0;
      m_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      m_q <= m_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  assign hi = hi_d;
  assign lo = lo_d;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle WIDTH-bit ALU with registered result/flags and valid/ready on both sides
// Ports: in_valid/in_ready + store/opcode/a/b request side; out_valid/out_ready + result,
// flags {Z,N,C,O} and illegal response side; clk with asynchronous active-low rst_n.
module alu_seq
  import alu_pkg::*;
#(parameter int WIDTH = 16, parameter int OPW = 6) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             store,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);
  localparam int LW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, alu_res, md_hi, md_lo, md_res, rot_r, rot_l;
  logic [3:0] flags_q, flags_d, alu_flags;
  logic [OPW-1:0] op_q, op_d;
  logic illegal_q, illegal_d, div0_q, div0_d, alu_c, alu_o, alu_ill, accept, md_start, md_done;
  logic [WIDTH:0] add_s, sub_s, lsr_x, lsl_x;
  logic [LW-1:0] rot_amt, rot_neg;
  alu_iter_muldiv #(.WIDTH(WIDTH)) u_md (
    .clk(clk), .rst_n(rst_n), .start(md_start), .is_div(opcode != OP_MUL),
    .a(a), .b(b), .done(md_done), .hi(md_hi), .lo(md_lo)
  );
  // single-cycle datapath; the extra bit of lsr_x/lsl_x catches the last bit shifted out
  always_comb begin
    add_s = {1'b0, a} + {1'b0, b};
    sub_s = {1'b0, a} - {1'b0, b};
    lsr_x = {a, 1'b0} >> b;
    lsl_x = {1'b0, a} << b;
    rot_amt = b[LW-1:0];
    rot_neg = '0 - rot_amt;
    rot_r = WIDTH'({a, a} >> rot_amt);
    rot_l = WIDTH'({a, a} >> rot_neg);
    alu_res = '0;
    alu_c = 1'b0;
    alu_o = 1'b0;
    alu_ill = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = add_s[WIDTH-1:0];
        alu_c = add_s[WIDTH];
        alu_o = a[WIDTH-1] == b[WIDTH-1] && add_s[WIDTH-1] != a[WIDTH-1];
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_s[WIDTH-1:0];
        alu_c = sub_s[WIDTH];
        alu_o = a[WIDTH-1] != b[WIDTH-1] && sub_s[WIDTH-1] != a[WIDTH-1];
      end
      OP_LSR: {alu_res, alu_c} = lsr_x;
      OP_LSL: {alu_c, alu_res} = lsl_x;
      OP_RSR: alu_res = rot_r;
      OP_RSL: alu_res = rot_l;
      OP_MOV: alu_res = b;
      OP_AND, OP_TST: alu_res = a & b;
      OP_OR: alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_INC: begin
        alu_res = a + 1'b1;
        alu_o = &a;
      end
      OP_DEC: begin
        alu_res = a - 1'b1;
        alu_o = ~|a;
      end
      OP_MUL, OP_DIV, OP_MOD: ;
      default: alu_ill = 1'b1;
    endcase
    alu_flags = alu_ill ? flags_q : opcode == OP_MOV ? 4'b0 : {alu_res == '0, alu_res[WIDTH-1], alu_c, alu_o};
  end
  always_comb begin
    accept = in_valid && state_q == S_IDLE;
    md_start = accept && !store && (opcode == OP_MUL || opcode == OP_DIV || opcode == OP_MOD);
    md_res = op_q == OP_MOD ? md_hi : md_lo;
    state_d = state_q;
    result_d = result_q;
    flags_d = flags_q;
    illegal_d = illegal_q;
    op_d = op_q;
    div0_d = div0_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d = opcode;
        div0_d = b == '0;
        state_d = md_start ? S_BUSY : S_DONE;
        result_d = md_start ? result_q : store ? a : alu_res;
        flags_d = md_start || store ? flags_q : alu_flags;
        illegal_d = !md_start && !store && alu_ill;
      end
      S_BUSY: if (md_done) begin
        state_d = S_DONE;
        result_d = md_res;
        flags_d = {md_res == '0, md_res[WIDTH-1], 1'b0, op_q == OP_MUL ? |md_hi : div0_q};
        illegal_d = 1'b0;
      end
      default: if (out_ready) state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      result_q <= '0;
      flags_q <= '0;
      illegal_q <= 1'b0;
      op_q <= '0;
      div0_q <= 1'b0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      flags_q <= flags_d;
      illegal_q <= illegal_d;
      op_q <= op_d;
      div0_q <= div0_d;
    end
  assign in_ready = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign result = result_q;
  assign flags = flags_q;
  assign illegal = illegal_q;
endmodule
